// File: rtl/mandelbrot_iter_engine.sv
// Per-pixel Mandelbrot iterator: z <= z^2 + c once per clock from z = 0, reporting
// escape iteration and in-set flag to the colour mapper via a start/done handshake.
module mandelbrot_iter_engine #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] c_re,
  input  logic [WIDTH-1:0] c_im,
  input  logic [5:0]       max_iter,
  output logic             busy,
  output logic             done,
  output logic [5:0]       iteration_count,
  output logic             in_set
);

  localparam int PW = 2*WIDTH;
  localparam int XW = 2*WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // 4.0 at the scale of a raw product (2*FRAC fraction bits)
  localparam logic [PW:0] ESC_LIM = {{(PW-2-2*FRAC){1'b0}}, 3'b100, {(2*FRAC){1'b0}}};
  localparam logic signed [XW-1:0] SMAX = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [1:0]              state;
  logic signed [WIDTH-1:0] z_re, z_im, cr, ci;
  logic [5:0]              iter, lim;

  logic signed [PW-1:0]    re_sq, im_sq, re_im;
  logic [PW:0]             mag_sq;
  logic signed [XW-1:0]    diff_w, im_w, re_sh, im_sh, nre_w, nim_w;
  logic signed [WIDTH-1:0] nre, nim;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SMAX)      return SMAX[WIDTH-1:0];
    else if (v < SMIN) return SMIN[WIDTH-1:0];
    else               return v[WIDTH-1:0];
  endfunction

  assign re_sq  = z_re * z_re;
  assign im_sq  = z_im * z_im;
  assign re_im  = z_re * z_im;
  // Squares are non-negative, so zero-extension keeps the full-precision magnitude
  assign mag_sq = {1'b0, re_sq} + {1'b0, im_sq};

  assign diff_w = {{2{re_sq[PW-1]}}, re_sq} - {{2{im_sq[PW-1]}}, im_sq};
  assign im_w   = {{2{re_im[PW-1]}}, re_im};
  assign re_sh  = diff_w >>> FRAC;
  assign im_sh  = im_w >>> (FRAC-1);   // one less shift doubles re*im
  assign nre_w  = re_sh + {{(XW-WIDTH){cr[WIDTH-1]}}, cr};
  assign nim_w  = im_sh + {{(XW-WIDTH){ci[WIDTH-1]}}, ci};
  assign nre    = sat(nre_w);
  assign nim    = sat(nim_w);

  assign busy = (state == S_ITER);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      z_re            <= '0;
      z_im            <= '0;
      cr              <= '0;
      ci              <= '0;
      lim             <= '0;
      iter            <= '0;
      iteration_count <= '0;
      in_set          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cr    <= c_re;
            ci    <= c_im;
            lim   <= max_iter;
            z_re  <= '0;
            z_im  <= '0;
            iter  <= '0;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          // Limit check precedes escape check, so reaching the limit always reports in-set
          if (iter == lim) begin
            iteration_count <= iter;
            in_set          <= 1'b1;
            state           <= S_DONE;
          end else if (mag_sq > ESC_LIM) begin
            iteration_count <= iter;
            in_set          <= 1'b0;
            state           <= S_DONE;
          end else begin
            z_re <= nre;
            z_im <= nim;
            iter <= iter + 6'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Directed bench for mandelbrot_iter_engine: hand-computed escape counts, latency,
// busy/done timing, boundary points and mid-run start/reset hazards.
module tb_mandelbrot_iter_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] c_re, c_im;
  logic [5:0]  max_iter;
  logic        busy, done;
  logic [5:0]  iteration_count;
  logic        in_set;

  int errors = 0;
  int checks = 0;

  mandelbrot_iter_engine #(.WIDTH(16), .FRAC(12)) dut (
    .clk(clk), .rst(rst), .start(start), .c_re(c_re), .c_im(c_im),
    .max_iter(max_iter), .busy(busy), .done(done),
    .iteration_count(iteration_count), .in_set(in_set)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one point and wait for done. k counts edges after the accepting edge;
  // done must first appear at k = N+1 (high through edge t+N+2), busy for N+1 samples.
  task automatic run_point(input string tag, input logic [15:0] cr, input logic [15:0] ci,
                           input logic [5:0] mi, input int exp_cnt, input logic exp_set,
                           input bit hazard);
    int  k;
    int  busy_cyc;
    bit  seen;
    @(negedge clk);
    c_re = cr; c_im = ci; max_iter = mi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    k = 0;
    busy_cyc = busy ? 1 : 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      if (hazard && k == 2) begin
        start = 1'b1; c_re = 16'h3000; c_im = 16'h1000; max_iter = 6'd0;
      end
      @(negedge clk);
      k++;
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
    end
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " latency"}, k, exp_cnt + 1);
    chk({tag, " busy_cycles"}, busy_cyc, exp_cnt + 1);
    chk({tag, " count"}, iteration_count, exp_cnt);
    chk({tag, " in_set"}, in_set, exp_set);
    @(negedge clk);
    // In hazard mode start is still high here, so this also shows DONE ignored it
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " idle_after_done"}, busy, 0);
    chk({tag, " count_held"}, iteration_count, exp_cnt);
    start = 1'b0;
  endtask

  initial begin
    int dpulse;
    rst = 1'b1; start = 1'b0; c_re = '0; c_im = '0; max_iter = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset count", iteration_count, 0);
    chk("reset in_set", in_set, 0);
    rst = 1'b0;

    run_point("c0_max63",   16'h0000, 16'h0000, 6'd63, 63, 1'b1, 1'b0);
    run_point("c3p0",       16'h3000, 16'h0000, 6'd63, 1,  1'b0, 1'b0);
    run_point("c0p5",       16'h0800, 16'h0000, 6'd63, 5,  1'b0, 1'b0);
    run_point("cm2p0",      16'hE000, 16'h0000, 6'd20, 20, 1'b1, 1'b0);
    run_point("c2p0",       16'h2000, 16'h0000, 6'd63, 2,  1'b0, 1'b0);
    run_point("max0",       16'h1234, 16'h0000, 6'd0,  0,  1'b1, 1'b0);
    // c = i cycles through i, -1+i, -i, -1+i, ... and never escapes
    run_point("ci1p0",      16'h0000, 16'h1000, 6'd10, 10, 1'b1, 1'b0);
    // c = 1.5i: z1 = 1.5i, z2 = -2.25+1.5i with |z|^2 = 7.3125
    run_point("ci1p5",      16'h0000, 16'h1800, 6'd63, 2,  1'b0, 1'b0);
    run_point("hazard_c0p5",16'h0800, 16'h0000, 6'd63, 5,  1'b0, 1'b1);

    // Reset at iter 10 of a c=0 run aborts without a done pulse
    @(negedge clk);
    c_re = '0; c_im = '0; max_iter = 6'd63; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst count", iteration_count, 0);
    chk("midrst in_set", in_set, 0);
    rst = 1'b0;
    dpulse = 0;
    repeat (70) begin
      @(negedge clk);
      if (done || busy) dpulse++;
    end
    chk("midrst no_activity", dpulse, 0);
    run_point("after_rst", 16'h3000, 16'h0000, 6'd63, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
